control_unit_fsm: RTL and testbench

- Hardwired Moore control sequencer that drives every strobe of the CPU datapath, replacing bench-driven control.
- Consumes the IR word, the CON FF result and an external stop request.
- Produces the bus-source, register-load, GRx select, memory, ALU opcode and PC-increment signals for one instruction at a time.
- Runs fetch (T0-T2), then opcode-specific execute steps (T3-T7), then returns to T0.

---
 rtl/cpu_defs.sv | 96 +++++++++
 rtl/control_unit_fsm_step_counter.sv | 44 ++++
 rtl/control_unit_fsm.sv | 265 ++++++++++++++++++++++++++
 tb/tb_control_unit_fsm.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// cpu_defs: opcode encodings, strobe bit positions and per-opcode sequencing helpers
// shared by the control sequencer and its step counter.
`default_nettype none

package cpu_defs;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_JAL  = 5'b10101;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [2:0] BS_HI     = 3'd0;
    localparam logic [2:0] BS_LO     = 3'd1;
    localparam logic [2:0] BS_ZHIGH  = 3'd2;
    localparam logic [2:0] BS_ZLOW   = 3'd3;
    localparam logic [2:0] BS_PC     = 3'd4;
    localparam logic [2:0] BS_MDR    = 3'd5;
    localparam logic [2:0] BS_INPORT = 3'd6;
    localparam logic [2:0] BS_C      = 3'd7;

    localparam logic [2:0] GS_BAOUT = 3'd0;
    localparam logic [2:0] GS_ROUT  = 3'd1;
    localparam logic [2:0] GS_RIN   = 3'd2;
    localparam logic [2:0] GS_GRC   = 3'd3;
    localparam logic [2:0] GS_GRB   = 3'd4;
    localparam logic [2:0] GS_GRA   = 3'd5;

    localparam logic [3:0] RL_PC      = 4'd0;
    localparam logic [3:0] RL_MAR     = 4'd1;
    localparam logic [3:0] RL_MDR     = 4'd2;
    localparam logic [3:0] RL_IR      = 4'd3;
    localparam logic [3:0] RL_Y       = 4'd4;
    localparam logic [3:0] RL_ZLOW    = 4'd5;
    localparam logic [3:0] RL_ZHIGH   = 4'd6;
    localparam logic [3:0] RL_LO      = 4'd7;
    localparam logic [3:0] RL_HI      = 4'd8;
    localparam logic [3:0] RL_OUTPORT = 4'd9;

    localparam logic [0:0] MEM_WRITE = 1'b0;
    localparam logic [0:0] MEM_READ  = 1'b1;

    // Final execute step of each opcode; anything not listed finishes at T3.
    function automatic logic [2:0] last_step(input logic [4:0] op);
        logic [2:0] s;
        s = 3'd3;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL,
            OP_ADDI, OP_ANDI, OP_ORI, OP_LDI:  s = 3'd5;
            OP_NEG, OP_NOT, OP_JAL:            s = 3'd4;
            OP_DIV, OP_MUL, OP_BR:             s = 3'd6;
            OP_LD, OP_ST:                      s = 3'd7;
            default:                           s = 3'd3;
        endcase
        return s;
    endfunction

    // Immediate forms reuse the ALU opcode of their register-register counterpart.
    function automatic logic [4:0] alu_op(input logic [4:0] op);
        logic [4:0] r;
        r = op;
        case (op)
            OP_ADDI: r = OP_ADD;
            OP_ANDI: r = OP_AND;
            OP_ORI:  r = OP_OR;
            default: r = op;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/control_unit_fsm_step_counter.sv
// control_unit_fsm_step_counter: T-step counter with synchronous clear, end-of-instruction
// restart and halt hold; wraps to T0 after T7.
`default_nettype none

module control_unit_fsm_step_counter #(
    parameter int STEP_W     = 3,
    parameter int RESET_STEP = 0
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              restart_i,
    input  logic              hold_i,
    output logic [STEP_W-1:0] step_o
);

    localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(7);

    logic [STEP_W-1:0] step_q;
    logic [STEP_W-1:0] step_d;

    always_comb begin
        step_d = step_q;
        if (hold_i) begin
            step_d = step_q;
        end else if (restart_i || (step_q >= STEP_MAX)) begin
            step_d = '0;
        end else begin
            step_d = step_q + STEP_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            step_q <= STEP_W'(RESET_STEP);
        end else begin
            step_q <= step_d;
        end
    end

    assign step_o = step_q;

endmodule

`default_nettype wire

// File: rtl/control_unit_fsm.sv
// control_unit_fsm: hardwired Moore sequencer producing every datapath strobe for a
// fetch (T0-T2) plus opcode-specific execute (T3-T7) instruction cycle.
`default_nettype none

module control_unit_fsm
    import cpu_defs::*;
#(
    parameter int STEP_W     = 3,
    parameter int RESET_STEP = 0
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] ir,
    input  logic        con_ff,
    input  logic        stop,
    output logic [7:0]  bus_src,
    output logic [5:0]  gsel,
    output logic [9:0]  reg_load,
    output logic        r15_in,
    output logic [1:0]  mem_rw,
    output logic        inc_pc,
    output logic        con_in,
    output logic [4:0]  operation,
    output logic        run
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    localparam logic [STEP_W-1:0] T0 = STEP_W'(0);
    localparam logic [STEP_W-1:0] T1 = STEP_W'(1);
    localparam logic [STEP_W-1:0] T2 = STEP_W'(2);
    localparam logic [STEP_W-1:0] T3 = STEP_W'(3);
    localparam logic [STEP_W-1:0] T4 = STEP_W'(4);
    localparam logic [STEP_W-1:0] T5 = STEP_W'(5);
    localparam logic [STEP_W-1:0] T6 = STEP_W'(6);
    localparam logic [STEP_W-1:0] T7 = STEP_W'(7);

    logic [0:0]        state_q;
    logic [0:0]        state_d;
    logic [STEP_W-1:0] step_q;
    logic [4:0]        opcode;
    logic              w_restart;
    logic              w_hold;
    logic              w_imm;
    logic              unused_ir_bits;

    assign opcode         = ir[31:27];
    assign unused_ir_bits = ^ir[26:0];
    assign w_imm          = (opcode == OP_ADDI) || (opcode == OP_ANDI) || (opcode == OP_ORI);
    assign w_restart      = (step_q >= T3) && (step_q == STEP_W'(last_step(opcode)));
    assign w_hold         = (state_q == ST_HALT) || ((step_q == T0) && stop);

    control_unit_fsm_step_counter #(
        .STEP_W     (STEP_W),
        .RESET_STEP (RESET_STEP)
    ) u_step_counter (
        .clock     (clock),
        .clear     (clear),
        .restart_i (w_restart),
        .hold_i    (w_hold),
        .step_o    (step_q)
    );

    always_comb begin
        state_d = state_q;
        if (state_q == ST_RUN) begin
            if ((step_q == T0) && stop) begin
                state_d = ST_HALT;
            end else if ((step_q == T3) && (opcode == OP_HALT)) begin
                state_d = ST_HALT;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign run = !clear || (state_q == ST_RUN);

    // Strobes are forced low while clear is held so nothing leaks during reset.
    always_comb begin
        bus_src   = '0;
        gsel      = '0;
        reg_load  = '0;
        r15_in    = 1'b0;
        mem_rw    = '0;
        inc_pc    = 1'b0;
        con_in    = 1'b0;
        operation = OP_ADD;
        if (!clear) begin
            operation = '0;
        end else if (state_q == ST_RUN) begin
            case (step_q)
                T0: begin
                    if (!stop) begin
                        bus_src[BS_PC]   = 1'b1;
                        reg_load[RL_MAR] = 1'b1;
                        reg_load[RL_PC]  = 1'b1;
                        inc_pc           = 1'b1;
                    end
                end
                T1: begin
                    mem_rw[MEM_READ] = 1'b1;
                    reg_load[RL_MDR] = 1'b1;
                end
                T2: begin
                    bus_src[BS_MDR] = 1'b1;
                    reg_load[RL_IR] = 1'b1;
                end
                default: begin
                    case (opcode)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA,
                        OP_SHL, OP_ADDI, OP_ANDI, OP_ORI: begin
                            if (step_q == T3) begin
                                gsel[GS_GRB]   = 1'b1;
                                gsel[GS_ROUT]  = 1'b1;
                                reg_load[RL_Y] = 1'b1;
                            end else if (step_q == T4) begin
                                if (w_imm) begin
                                    bus_src[BS_C] = 1'b1;
                                end else begin
                                    gsel[GS_GRC]  = 1'b1;
                                    gsel[GS_ROUT] = 1'b1;
                                end
                                operation         = alu_op(opcode);
                                reg_load[RL_ZLOW] = 1'b1;
                            end else if (step_q == T5) begin
                                bus_src[BS_ZLOW] = 1'b1;
                                gsel[GS_GRA]     = 1'b1;
                                gsel[GS_RIN]     = 1'b1;
                            end
                        end
                        OP_NEG, OP_NOT: begin
                            if (step_q == T3) begin
                                gsel[GS_GRB]      = 1'b1;
                                gsel[GS_ROUT]     = 1'b1;
                                operation         = opcode;
                                reg_load[RL_ZLOW] = 1'b1;
                            end else if (step_q == T4) begin
                                bus_src[BS_ZLOW] = 1'b1;
                                gsel[GS_GRA]     = 1'b1;
                                gsel[GS_RIN]     = 1'b1;
                            end
                        end
                        OP_MUL, OP_DIV: begin
                            if (step_q == T3) begin
                                gsel[GS_GRA]   = 1'b1;
                                gsel[GS_ROUT]  = 1'b1;
                                reg_load[RL_Y] = 1'b1;
                            end else if (step_q == T4) begin
                                gsel[GS_GRB]       = 1'b1;
                                gsel[GS_ROUT]      = 1'b1;
                                operation          = opcode;
                                reg_load[RL_ZLOW]  = 1'b1;
                                reg_load[RL_ZHIGH] = 1'b1;
                            end else if (step_q == T5) begin
                                bus_src[BS_ZLOW] = 1'b1;
                                reg_load[RL_LO]  = 1'b1;
                            end else if (step_q == T6) begin
                                bus_src[BS_ZHIGH] = 1'b1;
                                reg_load[RL_HI]   = 1'b1;
                            end
                        end
                        OP_LD, OP_LDI, OP_ST: begin
                            if (step_q == T3) begin
                                gsel[GS_GRB]   = 1'b1;
                                gsel[GS_BAOUT] = 1'b1;
                                reg_load[RL_Y] = 1'b1;
                            end else if (step_q == T4) begin
                                bus_src[BS_C]     = 1'b1;
                                reg_load[RL_ZLOW] = 1'b1;
                            end else if (step_q == T5) begin
                                bus_src[BS_ZLOW] = 1'b1;
                                if (opcode == OP_LDI) begin
                                    gsel[GS_GRA] = 1'b1;
                                    gsel[GS_RIN] = 1'b1;
                                end else begin
                                    reg_load[RL_MAR] = 1'b1;
                                end
                            end else if (step_q == T6) begin
                                reg_load[RL_MDR] = 1'b1;
                                if (opcode == OP_ST) begin
                                    gsel[GS_GRA]  = 1'b1;
                                    gsel[GS_ROUT] = 1'b1;
                                end else begin
                                    mem_rw[MEM_READ] = 1'b1;
                                end
                            end else if (step_q == T7) begin
                                if (opcode == OP_ST) begin
                                    mem_rw[MEM_WRITE] = 1'b1;
                                end else begin
                                    bus_src[BS_MDR] = 1'b1;
                                    gsel[GS_GRA]    = 1'b1;
                                    gsel[GS_RIN]    = 1'b1;
                                end
                            end
                        end
                        OP_BR: begin
                            if (step_q == T3) begin
                                gsel[GS_GRA]  = 1'b1;
                                gsel[GS_ROUT] = 1'b1;
                                con_in        = 1'b1;
                            end else if (step_q == T4) begin
                                bus_src[BS_PC] = 1'b1;
                                reg_load[RL_Y] = 1'b1;
                            end else if (step_q == T5) begin
                                bus_src[BS_C]     = 1'b1;
                                reg_load[RL_ZLOW] = 1'b1;
                            end else if (step_q == T6) begin
                                bus_src[BS_ZLOW] = 1'b1;
                                reg_load[RL_PC]  = con_ff;
                            end
                        end
                        OP_JR: begin
                            if (step_q == T3) begin
                                gsel[GS_GRA]    = 1'b1;
                                gsel[GS_ROUT]   = 1'b1;
                                reg_load[RL_PC] = 1'b1;
                            end
                        end
                        OP_JAL: begin
                            if (step_q == T3) begin
                                bus_src[BS_PC] = 1'b1;
                                r15_in         = 1'b1;
                            end else if (step_q == T4) begin
                                gsel[GS_GRA]    = 1'b1;
                                gsel[GS_ROUT]   = 1'b1;
                                reg_load[RL_PC] = 1'b1;
                            end
                        end
                        OP_IN, OP_MFHI, OP_MFLO: begin
                            if (step_q == T3) begin
                                bus_src[BS_INPORT] = (opcode == OP_IN);
                                bus_src[BS_HI]     = (opcode == OP_MFHI);
                                bus_src[BS_LO]     = (opcode == OP_MFLO);
                                gsel[GS_GRA]       = 1'b1;
                                gsel[GS_RIN]       = 1'b1;
                            end
                        end
                        OP_OUT: begin
                            if (step_q == T3) begin
                                gsel[GS_GRA]         = 1'b1;
                                gsel[GS_ROUT]        = 1'b1;
                                reg_load[RL_OUTPORT] = 1'b1;
                            end
                        end
                        OP_NOP, OP_HALT: begin
                        end
                        default: begin
                        end
                    endcase
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_control_unit_fsm.sv
// tb_control_unit_fsm: builds the expected per-cycle strobe sequence of each instruction
// as a queue and compares it against the sequencer cycle by cycle.
`default_nettype none

module tb_control_unit_fsm;

    logic        clock;
    logic        clear;
    logic [31:0] ir;
    logic        con_ff;
    logic        stop;
    logic [7:0]  bus_src;
    logic [5:0]  gsel;
    logic [9:0]  reg_load;
    logic        r15_in;
    logic [1:0]  mem_rw;
    logic        inc_pc;
    logic        con_in;
    logic [4:0]  operation;
    logic        run;

    int checks   = 0;
    int failures = 0;

    control_unit_fsm #(.STEP_W(3), .RESET_STEP(0)) dut (
        .clock     (clock),
        .clear     (clear),
        .ir        (ir),
        .con_ff    (con_ff),
        .stop      (stop),
        .bus_src   (bus_src),
        .gsel      (gsel),
        .reg_load  (reg_load),
        .r15_in    (r15_in),
        .mem_rw    (mem_rw),
        .inc_pc    (inc_pc),
        .con_in    (con_in),
        .operation (operation),
        .run       (run)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    localparam logic [7:0] COUT = 8'h80, INP = 8'h40, MDRO = 8'h20, PCO = 8'h10;
    localparam logic [7:0] ZLO = 8'h08, ZHO = 8'h04, LOO = 8'h02, HIO = 8'h01;
    localparam logic [5:0] GRA = 6'h20, GRB = 6'h10, GRC = 6'h08, RIN = 6'h04, ROUT = 6'h02, BAO = 6'h01;
    localparam logic [9:0] L_OUT = 10'h200, L_HI = 10'h100, L_LO = 10'h080, L_ZH = 10'h040, L_ZL = 10'h020;
    localparam logic [9:0] L_Y = 10'h010, L_IR = 10'h008, L_MDR = 10'h004, L_MAR = 10'h002, L_PC = 10'h001;
    localparam logic [1:0] RD = 2'b10, WR = 2'b01, NM = 2'b00;
    // x field = {IncPC, r15_in, con_in}
    localparam logic [2:0] X_INC = 3'b100, X_R15 = 3'b010, X_CON = 3'b001, X0 = 3'b000;
    localparam logic [4:0] ADD = 5'd3, AND_OP = 5'd5, OR_OP = 5'd6;
    localparam logic [4:0] I_LD = 5'd0, I_LDI = 5'd1, I_ST = 5'd2, I_ADD = 5'd3, I_MUL = 5'd16;
    localparam logic [4:0] I_BR = 5'd19, I_JR = 5'd20, I_JAL = 5'd21, I_HALT = 5'd27;

    logic [34:0] obs;
    assign obs = {bus_src, gsel, reg_load, r15_in, mem_rw, inc_pc, con_in, operation, run};

    function automatic logic [34:0] pk(input logic [7:0] b, input logic [5:0] g, input logic [9:0] l,
                                       input logic [1:0] m, input logic [2:0] x, input logic [4:0] opc,
                                       input logic r);
        return {b, g, l, x[1], m, x[2], x[0], opc, r};
    endfunction

    localparam logic [34:0] RESETV = {8'h00, 6'h00, 10'h000, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0, 1'b1};
    localparam logic [34:0] HALTV  = {8'h00, 6'h00, 10'h000, 1'b0, 2'b00, 1'b0, 1'b0, 5'd3, 1'b0};
    localparam logic [34:0] STOPV  = {8'h00, 6'h00, 10'h000, 1'b0, 2'b00, 1'b0, 1'b0, 5'd3, 1'b1};

    logic [34:0] expq[$];

    task automatic push(input logic [7:0] b, input logic [5:0] g, input logic [9:0] l,
                        input logic [1:0] m, input logic [2:0] x, input logic [4:0] opc);
        expq.push_back(pk(b, g, l, m, x, opc, 1'b1));
    endtask

    // Expected cycle-by-cycle behaviour of one complete instruction starting at T0.
    task automatic build(input logic [4:0] op, input logic c);
        expq.delete();
        push(PCO, 6'h00, L_MAR | L_PC, NM, X_INC, ADD);
        push(8'h00, 6'h00, L_MDR, RD, X0, ADD);
        push(MDRO, 6'h00, L_IR, NM, X0, ADD);
        if (op >= 5'd3 && op <= 5'd14) begin
            push(8'h00, GRB | ROUT, L_Y, NM, X0, ADD);
            if (op == 5'd12)      push(COUT, 6'h00, L_ZL, NM, X0, ADD);
            else if (op == 5'd13) push(COUT, 6'h00, L_ZL, NM, X0, AND_OP);
            else if (op == 5'd14) push(COUT, 6'h00, L_ZL, NM, X0, OR_OP);
            else                  push(8'h00, GRC | ROUT, L_ZL, NM, X0, op);
            push(ZLO, GRA | RIN, 10'h000, NM, X0, ADD);
        end else if (op == 5'd17 || op == 5'd18) begin
            push(8'h00, GRB | ROUT, L_ZL, NM, X0, op);
            push(ZLO, GRA | RIN, 10'h000, NM, X0, ADD);
        end else if (op == 5'd15 || op == 5'd16) begin
            push(8'h00, GRA | ROUT, L_Y, NM, X0, ADD);
            push(8'h00, GRB | ROUT, L_ZL | L_ZH, NM, X0, op);
            push(ZLO, 6'h00, L_LO, NM, X0, ADD);
            push(ZHO, 6'h00, L_HI, NM, X0, ADD);
        end else if (op <= 5'd2) begin
            push(8'h00, GRB | BAO, L_Y, NM, X0, ADD);
            push(COUT, 6'h00, L_ZL, NM, X0, ADD);
            if (op == I_LDI) begin
                push(ZLO, GRA | RIN, 10'h000, NM, X0, ADD);
            end else begin
                push(ZLO, 6'h00, L_MAR, NM, X0, ADD);
                if (op == I_LD) begin
                    push(8'h00, 6'h00, L_MDR, RD, X0, ADD);
                    push(MDRO, GRA | RIN, 10'h000, NM, X0, ADD);
                end else begin
                    push(8'h00, GRA | ROUT, L_MDR, NM, X0, ADD);
                    push(8'h00, 6'h00, 10'h000, WR, X0, ADD);
                end
            end
        end else if (op == I_BR) begin
            push(8'h00, GRA | ROUT, 10'h000, NM, X_CON, ADD);
            push(PCO, 6'h00, L_Y, NM, X0, ADD);
            push(COUT, 6'h00, L_ZL, NM, X0, ADD);
            push(ZLO, 6'h00, c ? L_PC : 10'h000, NM, X0, ADD);
        end else if (op == I_JR) begin
            push(8'h00, GRA | ROUT, L_PC, NM, X0, ADD);
        end else if (op == I_JAL) begin
            push(PCO, 6'h00, 10'h000, NM, X_R15, ADD);
            push(8'h00, GRA | ROUT, L_PC, NM, X0, ADD);
        end else if (op == 5'd22) begin
            push(INP, GRA | RIN, 10'h000, NM, X0, ADD);
        end else if (op == 5'd23) begin
            push(8'h00, GRA | ROUT, L_OUT, NM, X0, ADD);
        end else if (op == 5'd24) begin
            push(HIO, GRA | RIN, 10'h000, NM, X0, ADD);
        end else if (op == 5'd25) begin
            push(LOO, GRA | RIN, 10'h000, NM, X0, ADD);
        end else begin
            push(8'h00, 6'h00, 10'h000, NM, X0, ADD);
        end
    endtask

    task automatic chk(input string tag, input logic [34:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step_clk();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Checks the first n cycles (all when n<0) and leaves time at the next unchecked cycle.
    task automatic run_steps(input logic [4:0] op, input logic c, input int n, input logic [26:0] lo);
        build(op, c);
        ir     = {op, lo};
        con_ff = c;
        for (int i = 0; i < expq.size(); i++) begin
            if (n >= 0 && i >= n) break;
            chk($sformatf("op%0d_con%0d_T%0d", op, c, i), expq[i]);
            step_clk();
        end
    endtask

    initial begin
        logic [4:0] rop;
        logic       rc;
        clear  = 1'b0;
        stop   = 1'b0;
        ir     = '0;
        con_ff = 1'b0;
        step_clk();
        step_clk();
        chk("reset_initial", RESETV);
        clear = 1'b1;
        #1;

        run_steps(I_ADD, 1'b0, -1, 27'h0918000);

        // Abandon an add in T4 with a two-cycle clear.
        run_steps(I_ADD, 1'b0, 4, 27'h0918000);
        clear = 1'b0;
        step_clk();
        chk("reset_mid_1", RESETV);
        step_clk();
        chk("reset_mid_2", RESETV);
        clear = 1'b1;
        #1;
        run_steps(I_ADD, 1'b0, -1, 27'h0918000);

        run_steps(I_MUL, 1'b0, -1, 27'($urandom));
        run_steps(I_BR, 1'b0, -1, 27'($urandom));
        run_steps(I_BR, 1'b1, -1, 27'($urandom));
        run_steps(I_ST, 1'b0, -1, 27'($urandom));
        run_steps(I_LD, 1'b0, -1, 27'($urandom));
        run_steps(I_LDI, 1'b0, -1, 27'($urandom));
        run_steps(I_JAL, 1'b0, -1, 27'($urandom));

        for (int k = 0; k < 60; k++) begin
            rop = 5'($urandom_range(0, 31));
            if (rop == I_HALT) rop = 5'd26;
            rc = 1'($urandom_range(0, 1));
            run_steps(rop, rc, -1, 27'($urandom));
        end

        // A stop raised mid-instruction waits for the next T0.
        run_steps(I_JR, 1'b0, 2, 27'($urandom));
        stop = 1'b1;
        chk("stop_late_T2", expq[2]);
        step_clk();
        chk("stop_late_T3", expq[3]);
        step_clk();
        chk("stop_late_T0", STOPV);
        step_clk();
        chk("stop_late_halt", HALTV);
        stop  = 1'b0;
        clear = 1'b0;
        step_clk();
        chk("reset_after_stop", RESETV);
        clear = 1'b1;
        #1;

        run_steps(I_HALT, 1'b0, -1, 27'($urandom));
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("halted_%0d", k), HALTV);
            step_clk();
        end
        clear = 1'b0;
        step_clk();
        chk("reset_from_halt", RESETV);
        clear = 1'b1;
        #1;

        stop = 1'b1;
        #1;
        chk("stop_at_T0", STOPV);
        step_clk();
        chk("stop_halt", HALTV);
        stop = 1'b0;
        step_clk();
        chk("stop_hold", HALTV);
        clear = 1'b0;
        step_clk();
        clear = 1'b1;
        #1;
        run_steps(I_ADD, 1'b1, -1, 27'($urandom));
        chk("after_restart_T0", expq[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
